// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - Mode encodings, FSM state codes and initial patterns for the LED sequencer.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_BLINK    = 2'b00,
        MODE_WALK     = 2'b01,
        MODE_PINGPONG = 2'b10,
        MODE_COUNT    = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_PAUSED = 2'b10
    } state_t;

    localparam logic [7:0] INIT_BLINK    = 8'hFF;
    localparam logic [7:0] INIT_WALK     = 8'h01;
    localparam logic [7:0] INIT_PINGPONG = 8'h01;
    localparam logic [7:0] INIT_COUNT    = 8'h00;

    function automatic logic [7:0] init_pattern(input mode_t m);
        case (m)
            MODE_BLINK:    init_pattern = INIT_BLINK;
            MODE_WALK:     init_pattern = INIT_WALK;
            MODE_PINGPONG: init_pattern = INIT_PINGPONG;
            default:       init_pattern = INIT_COUNT;
        endcase
    endfunction

endpackage

// File: rtl/led_step_timer.sv
// rtl/led_step_timer.sv - Prescaler producing one step per (BASE_DIV >> speed) running cycles.
module led_step_timer #(
    parameter int unsigned BASE_DIV = 50_000_000,
    parameter int unsigned CNT_W    = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       clear,
    input  logic [1:0] speed,
    output logic       tick,
    output logic       step
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] limit;

    // >= rather than == so that a speed increase past the current count wraps at once
    assign limit = CNT_W'((BASE_DIV >> speed) - 1);
    assign tick  = run && (cnt >= limit);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            step <= 1'b0;
        end else if (clear) begin
            cnt  <= '0;
            step <= 1'b0;
        end else if (run) begin
            cnt  <= tick ? '0 : cnt + 1'b1;
            step <= tick;
        end else begin
            step <= 1'b0;
        end
    end

endmodule

// File: rtl/led_pattern_sequencer.sv
// rtl/led_pattern_sequencer.sv - Start/stop/pause LED pattern scheduler; LED_PWM_EN adds a brightness PWM stage.
module led_pattern_sequencer
    import led_pkg::*;
#(
    parameter int unsigned BASE_DIV = 50_000_000,
    parameter int unsigned CNT_W    = 26
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    input  logic [1:0] mode,
    input  logic [1:0] speed,
`ifdef LED_PWM_EN
    input  logic [2:0] brightness,
`endif
    output logic [7:0] LEDG,
    output logic       busy,
    output logic       step
);

    state_t     state;
    mode_t      mode_q;
    logic [7:0] pattern;
    logic       dir_up;
    logic       active;
    logic       timer_run;
    logic       timer_clear;
    logic       tick;

    assign active      = (state != ST_IDLE);
    assign timer_run   = active && !pause && !stop && !start;
    assign timer_clear = start || stop;

    led_step_timer #(
        .BASE_DIV (BASE_DIV),
        .CNT_W    (CNT_W)
    ) u_timer (
        .clk   (CLOCK_50),
        .reset (reset),
        .run   (timer_run),
        .clear (timer_clear),
        .speed (speed),
        .tick  (tick),
        .step  (step)
    );

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state   <= ST_IDLE;
            mode_q  <= MODE_BLINK;
            pattern <= 8'h00;
            dir_up  <= 1'b1;
            busy    <= 1'b0;
        end else if (stop) begin
            state   <= ST_IDLE;
            pattern <= 8'h00;
            dir_up  <= 1'b1;
            busy    <= 1'b0;
        end else if (start) begin
            state   <= ST_RUN;
            mode_q  <= mode_t'(mode);
            pattern <= init_pattern(mode_t'(mode));
            dir_up  <= 1'b1;
            busy    <= 1'b1;
        end else if (active) begin
            state <= pause ? ST_PAUSED : ST_RUN;
            if (tick) begin
                case (mode_q)
                    MODE_BLINK: pattern <= ~pattern;
                    MODE_WALK:  pattern <= {pattern[6:0], pattern[7]};
                    MODE_PINGPONG: begin
                        // direction flips on the step that lands on an end bit
                        if (dir_up) begin
                            pattern <= pattern << 1;
                            if (pattern == 8'h40) dir_up <= 1'b0;
                        end else begin
                            pattern <= pattern >> 1;
                            if (pattern == 8'h02) dir_up <= 1'b1;
                        end
                    end
                    default:    pattern <= pattern + 8'h01;
                endcase
            end
        end
    end

`ifdef LED_PWM_EN
    logic [2:0] pwm_cnt;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            pwm_cnt <= 3'd0;
            LEDG    <= 8'h00;
        end else begin
            pwm_cnt <= pwm_cnt + 3'd1;
            LEDG    <= pattern & {8{pwm_cnt <= brightness}};
        end
    end
`else
    assign LEDG = pattern;
`endif

endmodule
